// File: rtl/tmr_alarm_sched_pkg.sv
// Shared definitions for the alarm scheduler: default sizing, scan state
// encoding and the per-channel mode flags.
package tmr_alarm_sched_pkg;

  localparam int TMR_SCHED_CH_NUM    = 4;
  localparam int TMR_SCHED_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } scan_state_e;

  // Mode bits of one alarm channel. The deadline and period words live next
  // to this struct inside the channel, sized by the instance's CNT_WIDTH.
  typedef struct packed {
    logic armed;
    logic periodic;
  } tmr_sched_mode_t;

endpackage

// File: rtl/tmr_sched_ch.sv
// One alarm channel: arm/cancel bookkeeping, deadline compare, periodic
// reload and the pending/miss flags.
module tmr_sched_ch
  import tmr_alarm_sched_pkg::*;
#(
  parameter int CNT_WIDTH = TMR_SCHED_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 tick_i,
  input  logic [CNT_WIDTH-1:0] now_d_i,
  input  logic                 arm_i,
  input  logic [CNT_WIDTH-1:0] arm_delta_i,
  input  logic                 arm_periodic_i,
  input  logic                 cancel_i,
  input  logic                 irq_clr_i,
  output logic                 fire_o,
  output logic                 armed_o,
  output logic                 irq_o,
  output logic                 miss_o,
  output logic [CNT_WIDTH-1:0] deadline_o
);

  tmr_sched_mode_t      mode_q, mode_d;
  logic [CNT_WIDTH-1:0] deadline_q, deadline_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 irq_q, irq_d;
  logic                 miss_q, miss_d;
  logic                 fire;

  // On a tick, now_d equals now_q + 1, so this is the "next count hits the
  // deadline" match without a second adder.
  assign fire = tick_i && mode_q.armed && (now_d_i == deadline_q);

  // Next channel state: arm overrides cancel, cancel overrides reload/disarm.
  always_comb begin
    mode_d     = mode_q;
    deadline_d = deadline_q;
    period_d   = period_q;
    if (arm_i) begin
      mode_d.armed    = 1'b1;
      mode_d.periodic = arm_periodic_i;
      deadline_d      = now_d_i + arm_delta_i;
      period_d        = arm_delta_i;
    end else if (cancel_i) begin
      mode_d.armed = 1'b0;
    end else if (fire) begin
      if (mode_q.periodic) begin
        deadline_d = deadline_q + period_q;
      end else begin
        mode_d.armed = 1'b0;
      end
    end
  end

  // Pending and miss flags: a fire in the same cycle beats the clear strobe.
  always_comb begin
    irq_d  = irq_q;
    miss_d = miss_q;
    if (irq_clr_i) begin
      irq_d  = 1'b0;
      miss_d = 1'b0;
    end
    if (fire) begin
      irq_d = 1'b1;
      if (irq_q) begin
        miss_d = 1'b1;
      end
    end
  end

  // Channel register bank.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mode_q     <= '0;
      deadline_q <= '0;
      period_q   <= '0;
      irq_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      deadline_q <= deadline_d;
      period_q   <= period_d;
      irq_q      <= irq_d;
      miss_q     <= miss_d;
    end
  end

  assign fire_o     = fire;
  assign armed_o    = mode_q.armed;
  assign irq_o      = irq_q;
  assign miss_o     = miss_q;
  assign deadline_o = deadline_q;

endmodule

// File: rtl/tmr_alarm_sched.sv
// Alarm scheduler top: shared time base, per-channel alarms and a scan
// engine that reports the earliest armed deadline.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no valid earliest deadline; waiting for a change
// ST_SCAN | walking channels 0..CH_NUM-1, one per cycle, keeping the min
// ST_HOLD | next_id/next_rem valid until another change is seen
module tmr_alarm_sched
  import tmr_alarm_sched_pkg::*;
#(
  parameter int  CH_NUM    = TMR_SCHED_CH_NUM,
  parameter int  CNT_WIDTH = TMR_SCHED_CNT_WIDTH,
  localparam int ID_WIDTH  = $clog2(CH_NUM)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 tick_i,
  input  logic                 arm_valid_i,
  output logic                 arm_ready_o,
  input  logic [ID_WIDTH-1:0]  arm_id_i,
  input  logic [CNT_WIDTH-1:0] arm_delta_i,
  input  logic                 arm_periodic_i,
  output logic                 arm_err_o,
  input  logic                 cancel_valid_i,
  input  logic [ID_WIDTH-1:0]  cancel_id_i,
  input  logic [CH_NUM-1:0]    irq_clr_i,
  output logic [CH_NUM-1:0]    irq_o,
  output logic [CH_NUM-1:0]    miss_o,
  output logic [CH_NUM-1:0]    armed_o,
  output logic [CNT_WIDTH-1:0] now_o,
  output logic                 next_valid_o,
  output logic [ID_WIDTH-1:0]  next_id_o,
  output logic [CNT_WIDTH-1:0] next_rem_o
);

  localparam logic [ID_WIDTH-1:0] LAST_IDX = ID_WIDTH'(CH_NUM - 1);

  logic [CNT_WIDTH-1:0] now_q, now_d;
  logic                 arm_err_q;
  logic                 arm_accept;
  logic [CH_NUM-1:0]    fire_w;
  logic [CH_NUM-1:0]    armed_w;
  logic [CNT_WIDTH-1:0] deadline_w [CH_NUM];

  logic                 dirty_q, dirty_d;
  logic                 dirty_set, dirty_eff;

  scan_state_e          state_q, state_d;
  logic                 scan_restart;
  logic [ID_WIDTH-1:0]  idx_q, idx_d;
  logic                 best_valid_q, best_valid_d;
  logic [ID_WIDTH-1:0]  best_id_q, best_id_d;
  logic [CNT_WIDTH-1:0] best_rem_q, best_rem_d;
  logic [ID_WIDTH-1:0]  next_id_q, next_id_d;
  logic [CNT_WIDTH-1:0] rem_cur;
  logic                 take;
  logic                 cand_found;

  assign now_d       = now_q + CNT_WIDTH'(tick_i);
  assign arm_accept  = arm_valid_i && (arm_delta_i != '0);
  assign arm_ready_o = 1'b1;
  assign arm_err_o   = arm_err_q;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    tmr_sched_ch #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk_i          (clk_i),
      .rst_n_i        (rst_n_i),
      .tick_i         (tick_i),
      .now_d_i        (now_d),
      .arm_i          (arm_accept && (arm_id_i == ID_WIDTH'(g))),
      .arm_delta_i    (arm_delta_i),
      .arm_periodic_i (arm_periodic_i),
      .cancel_i       (cancel_valid_i && (cancel_id_i == ID_WIDTH'(g))),
      .irq_clr_i      (irq_clr_i[g]),
      .fire_o         (fire_w[g]),
      .armed_o        (armed_w[g]),
      .irq_o          (irq_o[g]),
      .miss_o         (miss_o[g]),
      .deadline_o     (deadline_w[g])
    );
  end

  assign armed_o = armed_w;
  assign now_o   = now_q;

  // A change seen this cycle is folded in immediately so the scan can start
  // on the very next cycle, when the channel registers already hold it.
  assign dirty_set = arm_accept || cancel_valid_i || (|fire_w);
  assign dirty_eff = dirty_q || dirty_set;
  assign dirty_d   = scan_restart ? 1'b0 : dirty_eff;

  // Differences to the same now_q keep their order across wrap, so an
  // unsigned compare of remaining ticks finds the earliest deadline.
  assign rem_cur    = deadline_w[idx_q] - now_q;
  assign take       = armed_w[idx_q] && (!best_valid_q || (rem_cur < best_rem_q));
  assign cand_found = best_valid_q || take;

  // Time base, arm error pulse and dirty flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      now_q     <= '0;
      arm_err_q <= 1'b0;
      dirty_q   <= 1'b0;
    end else begin
      now_q     <= now_d;
      arm_err_q <= arm_valid_i && (arm_delta_i == '0);
      dirty_q   <= dirty_d;
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Scan FSM next-state logic; scan_restart marks entry at channel 0.
  always_comb begin
    state_d      = state_q;
    scan_restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dirty_set || (dirty_q && (|armed_w))) begin
          state_d      = ST_SCAN;
          scan_restart = 1'b1;
        end
      end
      ST_SCAN: begin
        if (dirty_eff) begin
          scan_restart = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d = cand_found ? ST_HOLD : ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (dirty_eff) begin
          state_d      = ST_SCAN;
          scan_restart = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Scan datapath: channel index, running minimum and the reported id.
  always_comb begin
    idx_d        = idx_q;
    best_valid_d = best_valid_q;
    best_id_d    = best_id_q;
    best_rem_d   = best_rem_q;
    next_id_d    = next_id_q;
    if (scan_restart) begin
      idx_d        = '0;
      best_valid_d = 1'b0;
      best_id_d    = '0;
      best_rem_d   = '0;
    end else if (state_q == ST_SCAN) begin
      if (take) begin
        best_valid_d = 1'b1;
        best_id_d    = idx_q;
        best_rem_d   = rem_cur;
      end
      if (idx_q != LAST_IDX) begin
        idx_d = idx_q + ID_WIDTH'(1);
      end else begin
        next_id_d = take ? idx_q : best_id_q;
      end
    end
  end

  // Scan datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q        <= '0;
      best_valid_q <= 1'b0;
      best_id_q    <= '0;
      best_rem_q   <= '0;
      next_id_q    <= '0;
    end else begin
      idx_q        <= idx_d;
      best_valid_q <= best_valid_d;
      best_id_q    <= best_id_d;
      best_rem_q   <= best_rem_d;
      next_id_q    <= next_id_d;
    end
  end

  // Scan FSM outputs; remaining ticks follow the live time base while held.
  always_comb begin
    next_valid_o = 1'b0;
    next_id_o    = '0;
    next_rem_o   = '0;
    if (state_q == ST_HOLD) begin
      next_valid_o = 1'b1;
      next_id_o    = next_id_q;
      next_rem_o   = deadline_w[next_id_q] - now_q;
    end
  end

endmodule

// File: tb/tb_tmr_alarm_sched.sv
// Directed bench for the alarm scheduler (4 channels, 16-bit time base).
module tb_tmr_alarm_sched;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        tick_i;
  logic        arm_valid_i;
  logic        arm_ready_o;
  logic [1:0]  arm_id_i;
  logic [15:0] arm_delta_i;
  logic        arm_periodic_i;
  logic        arm_err_o;
  logic        cancel_valid_i;
  logic [1:0]  cancel_id_i;
  logic [3:0]  irq_clr_i;
  logic [3:0]  irq_o;
  logic [3:0]  miss_o;
  logic [3:0]  armed_o;
  logic [15:0] now_o;
  logic        next_valid_o;
  logic [1:0]  next_id_o;
  logic [15:0] next_rem_o;

  int n_cmp = 0;
  int n_err = 0;

  tmr_alarm_sched #(
    .CH_NUM    (4),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .tick_i         (tick_i),
    .arm_valid_i    (arm_valid_i),
    .arm_ready_o    (arm_ready_o),
    .arm_id_i       (arm_id_i),
    .arm_delta_i    (arm_delta_i),
    .arm_periodic_i (arm_periodic_i),
    .arm_err_o      (arm_err_o),
    .cancel_valid_i (cancel_valid_i),
    .cancel_id_i    (cancel_id_i),
    .irq_clr_i      (irq_clr_i),
    .irq_o          (irq_o),
    .miss_o         (miss_o),
    .armed_o        (armed_o),
    .now_o          (now_o),
    .next_valid_o   (next_valid_o),
    .next_id_o      (next_id_o),
    .next_rem_o     (next_rem_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given tick level; returns 1 time unit after the edge.
  task automatic cyc(input bit tk);
    tick_i = tk;
    @(posedge clk_i);
    #1;
    tick_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  // n ticks at one tick every second clock.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
  endtask

  task automatic arm(input int id, input int delta, input bit per);
    arm_valid_i    = 1'b1;
    arm_id_i       = id[1:0];
    arm_delta_i    = delta[15:0];
    arm_periodic_i = per;
    cyc(1'b0);
    arm_valid_i    = 1'b0;
    arm_delta_i    = '0;
    arm_periodic_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #3;
    rst_n_i = 1'b1;
    cyc(1'b0);
  endtask

  initial begin
    rst_n_i        = 1'b1;
    tick_i         = 1'b0;
    arm_valid_i    = 1'b0;
    arm_id_i       = '0;
    arm_delta_i    = '0;
    arm_periodic_i = 1'b0;
    cancel_valid_i = 1'b0;
    cancel_id_i    = '0;
    irq_clr_i      = '0;
    #1;
    do_reset();

    // Reset state
    chk("rst_ready", arm_ready_o, 1);
    chk("rst_irq", irq_o, 0);
    chk("rst_miss", miss_o, 0);
    chk("rst_armed", armed_o, 0);
    chk("rst_now", now_o, 0);
    chk("rst_nvalid", next_valid_o, 0);
    chk("rst_err", arm_err_o, 0);

    // One-shot ch2 delta=5 at now=0x10, plus scan latency
    tick_n(16);
    chk("a_now", now_o, 16'h0010);
    arm(2, 5, 1'b0);
    chk("a_armed", armed_o, 4'b0100);
    idle(3);
    chk("a_lat_lo", next_valid_o, 0);
    idle(1);
    chk("a_lat_hi", next_valid_o, 1);
    chk("a_id", next_id_o, 2);
    chk("a_rem", next_rem_o, 5);
    tick_n(4);
    chk("a_rem1", next_rem_o, 1);
    chk("a_irq_pre", irq_o, 0);
    tick_n(1);
    chk("a_fire_now", now_o, 16'h0015);
    chk("a_fire_irq", irq_o, 4'b0100);
    chk("a_disarm", armed_o, 0);
    irq_clr_i = 4'b0100;
    cyc(1'b0);
    irq_clr_i = '0;
    tick_n(20);
    chk("a_nofire", irq_o, 0);
    chk("a_nvalid", next_valid_o, 0);

    // Periodic ch0 delta=3, miss on second fire, then W1C
    do_reset();
    arm(0, 3, 1'b1);
    tick_n(3);
    chk("b_irq1", irq_o, 4'b0001);
    chk("b_miss1", miss_o, 0);
    tick_n(3);
    chk("b_now6", now_o, 6);
    chk("b_miss2", miss_o, 4'b0001);
    chk("b_armed", armed_o, 4'b0001);
    irq_clr_i = 4'b0001;
    cyc(1'b0);
    irq_clr_i = '0;
    chk("b_clr_irq", irq_o, 0);
    chk("b_clr_miss", miss_o, 0);
    tick_n(3);
    chk("b_now9", now_o, 9);
    chk("b_irq3", irq_o, 4'b0001);
    chk("b_miss3", miss_o, 0);

    // ch1 and ch3 with equal deadlines: tie to lower index, joint fire
    do_reset();
    arm(1, 4, 1'b0);
    arm(3, 4, 1'b0);
    idle(4);
    chk("c_valid", next_valid_o, 1);
    chk("c_tie_id", next_id_o, 1);
    chk("c_rem", next_rem_o, 4);
    tick_n(3);
    chk("c_irq_pre", irq_o, 0);
    tick_n(1);
    chk("c_irq_both", irq_o, 4'b1010);

    // Wrap of the time base
    do_reset();
    for (int i = 0; i < 65534; i++) cyc(1'b1);
    chk("d_now_fffe", now_o, 16'hFFFE);
    arm(0, 4, 1'b0);
    idle(4);
    chk("d_rem4", next_rem_o, 4);
    tick_n(1);
    chk("d_rem3", next_rem_o, 3);
    tick_n(1);
    chk("d_now_wrap", now_o, 0);
    chk("d_rem2", next_rem_o, 2);
    tick_n(1);
    chk("d_rem1", next_rem_o, 1);
    chk("d_irq_pre", irq_o, 0);
    tick_n(1);
    chk("d_irq", irq_o, 4'b0001);
    chk("d_now2", now_o, 2);

    // Zero delta rejected; arm beats cancel on the same id
    do_reset();
    arm(2, 0, 1'b0);
    chk("e_err", arm_err_o, 1);
    chk("e_armed", armed_o, 0);
    cyc(1'b0);
    chk("e_err_end", arm_err_o, 0);
    arm_valid_i    = 1'b1;
    arm_id_i       = 2'd2;
    arm_delta_i    = 16'd7;
    cancel_valid_i = 1'b1;
    cancel_id_i    = 2'd2;
    cyc(1'b0);
    arm_valid_i    = 1'b0;
    cancel_valid_i = 1'b0;
    chk("e_arm_wins", armed_o, 4'b0100);
    chk("e_err_none", arm_err_o, 0);

    // Cancel of the reported channel forces a rescan; async reset mid-scan
    do_reset();
    arm(1, 100, 1'b0);
    arm(2, 50, 1'b0);
    idle(4);
    chk("f_valid", next_valid_o, 1);
    chk("f_id2", next_id_o, 2);
    tick_n(2);
    chk("f_rem48", next_rem_o, 48);
    cancel_valid_i = 1'b1;
    cancel_id_i    = 2'd2;
    cyc(1'b0);
    cancel_valid_i = 1'b0;
    chk("f_drop", next_valid_o, 0);
    idle(3);
    chk("f_still_lo", next_valid_o, 0);
    idle(1);
    chk("f_back", next_valid_o, 1);
    chk("f_id1", next_id_o, 1);
    chk("f_rem98", next_rem_o, 98);
    arm(3, 10, 1'b1);
    cyc(1'b0);
    rst_n_i = 1'b0;
    #2;
    chk("f_rst_armed", armed_o, 0);
    chk("f_rst_now", now_o, 0);
    chk("f_rst_nvalid", next_valid_o, 0);
    chk("f_rst_id", next_id_o, 0);
    rst_n_i = 1'b1;
    tick_n(12);
    chk("f_no_fire", irq_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tmr_alarm_sched.md
Name: tmr_alarm_sched

Overview:
- Multiplexes N independent software alarms (one-shot or periodic) onto one shared timer time base.
- The time base advances on a prescaled tick, normally the clk_int_div_simple trigger pulse.
- Per-channel deadlines are compared in parallel; matches raise per-channel interrupt-pending bits.
- A sequential scan engine continuously reports the earliest pending deadline (id and remaining ticks) for APB status and low-power wakeup logic.

Parameters:
- CH_NUM, 4, number of alarm channels (2..16).
- CNT_WIDTH, 32, width of the time base, deadlines and deltas.
- ID_WIDTH, $clog2(CH_NUM), channel index width (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- tick_i  in  1  one-cycle time-base advance pulse
- arm_valid_i  in  1  arm request
- arm_ready_o  out  1  arm accept
- arm_id_i  in  ID_WIDTH  channel to arm
- arm_delta_i  in  CNT_WIDTH  ticks until first fire; also the period
- arm_periodic_i  in  1  1=periodic, 0=one-shot
- arm_err_o  out  1  one-cycle pulse: arm rejected (delta==0)
- cancel_valid_i  in  1  disarm request (always accepted)
- cancel_id_i  in  ID_WIDTH  channel to disarm
- irq_clr_i  in  CH_NUM  per-channel pending clear (W1C strobe from APB)
- irq_o  out  CH_NUM  per-channel pending flags
- miss_o  out  CH_NUM  sticky: channel fired while already pending; cleared with irq_clr_i
- armed_o  out  CH_NUM  per-channel armed state
- now_o  out  CNT_WIDTH  time base value
- next_valid_o  out  1  next_id_o/next_rem_o are valid
- next_id_o  out  ID_WIDTH  channel with the earliest deadline
- next_rem_o  out  CNT_WIDTH  ticks remaining to that deadline

Behaviour:
- Reset: all registers and outputs 0, FSM in IDLE, arm_ready_o=1 (combinational).
- Time base:
  - now_q increments by 1 on tick_i and wraps modulo 2^CNT_WIDTH.
  - now_d denotes now_q + tick_i.
- Arm:
  - Accepted when arm_valid_i is high; arm_ready_o is constantly 1.
  - If delta==0: no state change and arm_err_o pulses the next cycle.
  - Otherwise: deadline[id]=now_d+delta (wrapping), period[id]=delta, periodic[id]=arm_periodic_i, armed[id]=1.
  - Re-arming an armed channel overwrites it.
  - Pending and miss flags are untouched.
- Cancel: armed[id]=0. If arm and cancel target the same id in the same cycle, arm wins.
- Fire:
  - Channel i fires when tick_i && armed[i] && now_q+1==deadline[i].
  - All matching channels fire in the same cycle.
  - On fire: irq[i]=1; if irq[i] was already 1, miss[i]=1.
  - Periodic channels: deadline[i]+=period[i] (wrapping) and stay armed. One-shot channels: armed[i]=0.
  - An arm to the same channel in the fire cycle overrides the reload/disarm, but the pending bit is still set.
- Pending clear: irq_clr_i[i] clears irq[i] and miss[i]. A simultaneous fire wins (flag stays 1).
- Dirty flag: set by any accepted arm, any cancel, or any fire.
- Scan FSM, states IDLE, SCAN, HOLD:
  - IDLE: next_valid_o=0. If dirty and any armed, go to SCAN at idx=0 and clear dirty.
  - SCAN: one channel per cycle.
    - rem=deadline[idx]-now_q (unsigned, wrapping).
    - Keep the minimum rem among armed channels; ties go to the lower index.
    - If dirty is raised mid-scan: restart at idx=0 and clear dirty.
    - After idx==CH_NUM-1: go to HOLD if a candidate was found, else IDLE.
  - HOLD:
    - next_valid_o=1; next_id_o registered; next_rem_o=deadline[next_id]-now_q (combinational, tracks ticks).
    - On dirty: go to SCAN and drop next_valid_o the following cycle.
  - Latency: from an accepted arm in cycle t, next_valid_o rises in cycle t+1+CH_NUM.
- Width rules:
  - All deadline/remaining arithmetic is modulo 2^CNT_WIDTH.
  - Maximum representable delay is 2^CNT_WIDTH-1 ticks.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); no fire is generated on reset release.

Decomposition:
- Shared package (tmr_define additions):
  - TMR_SCHED_CH_NUM default.
  - Scan state enum {IDLE, SCAN, HOLD}.
  - Per-channel struct {armed, periodic, deadline, period}.
- Sub-module tmr_sched_ch, instantiated CH_NUM times via generate:
  - Holds the per-channel registers, fire comparator, reload adder, irq/miss flags.
  - Outputs fire, armed and deadline.
- Top level holds the time base, dirty flag and scan FSM.

Test Plan (CH_NUM=4, CNT_WIDTH=16, tick_i every 2nd clock):
- Arm ch2 delta=5 one-shot at now=0x0010 -> irq_o[2] rises on the tick making now=0x0015; armed_o[2]=0; no further fire after 20 more ticks.
- Arm ch0 periodic delta=3 at now=0 -> fires at now=3,6,9. Leave irq uncleared until second fire -> miss_o[0]=1. irq_clr_i[0] -> both flags clear.
- Arm ch1 delta=4 and ch3 delta=4 in consecutive cycles without an intervening tick -> both fire on the same tick; scan reports next_id_o=1 (tie, lower index) before that.
- Preload now=0xFFFE (tick until then), arm ch0 delta=4 -> deadline=0x0002, fires after wrap; next_rem_o counts 4,3,2,1.
- Arm ch2 delta=0 -> arm_err_o pulses one cycle; armed_o unchanged. Arm and cancel ch2 in the same cycle -> ch2 armed.
- Arm ch1 delta=100 and ch2 delta=50. After next_valid_o=1 (next_id=2), cancel ch2 -> next_valid_o drops next cycle, returns after 4 cycles with next_id=1. Assert rst_n_i low mid-scan -> all outputs 0 asynchronously.
